// File: rtl/mc_freq_mult.sv
// rtl/mc_freq_mult.sv - frequency-domain complex multiply stage with a reloadable coefficient frame
//
// Purpose: stores one N-point complex coefficient frame, then multiplies every
// streamed spectrum sample by the coefficient at the same frame index.
// Result = (a * b) >>> FRAC, with optional conjugation of the result, reduced to DW bits.
//
// Parameters: DW (sample width), N (frame length, power of two), FRAC (right shift)
// Optional build macro: MC_FMULT_SAT_EN
//   defined   -> results clamp to the DW-bit range and set a sticky sat_flag
//   undefined -> results wrap (low DW bits) and sat_flag is tied to 0
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   coef_valid/coef_real/coef_img    coefficient write stream (accepted in LOAD)
//   coef_ready                       high in LOAD
//   reload                           request a new coefficient frame
//   in_valid/in_real/in_img/conj_en  spectrum sample stream (accepted in RUN)
//   in_ready                         high in RUN unless a reload is due at the frame boundary
//   out_valid/out_real/out_img       product stream, 2 cycles after acceptance
//   frame_done                       marks the result for frame index N-1
//   sat_flag                         sticky clamp indicator
module mc_freq_mult #(
    parameter int DW   = 16,
    parameter int N    = 256,
    parameter int FRAC = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          coef_valid,
    input  logic [DW-1:0] coef_real,
    input  logic [DW-1:0] coef_img,
    output logic          coef_ready,
    input  logic          reload,
    input  logic          in_valid,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_img,
    output logic          in_ready,
    input  logic          conj_en,
    output logic          out_valid,
    output logic [DW-1:0] out_real,
    output logic [DW-1:0] out_img,
    output logic          frame_done,
    output logic          sat_flag
);
    localparam int AW = $clog2(N);
    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] cidx;
    logic [AW-1:0] sidx;
    logic          pending;
    logic          coef_wr;
    logic          in_acc;

    logic signed [DW-1:0] coef_re_mem [N];
    logic signed [DW-1:0] coef_im_mem [N];

    assign coef_wr = coef_ready && coef_valid;
    assign in_acc  = in_ready && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: if (coef_valid && cidx == AW'(N - 1)) state_nxt = S_RUN;
            S_RUN:  if (pending && sidx == '0) state_nxt = S_LOAD;
            default: state_nxt = S_LOAD;
        endcase
    end

    // A pending reload parks the stream at index 0 for one cycle so the
    // frame just completed is never split across two coefficient sets.
    always_comb begin
        coef_ready = 1'b0;
        in_ready   = 1'b0;
        case (state)
            S_LOAD: coef_ready = 1'b1;
            S_RUN:  in_ready   = !(pending && sidx == '0);
            default: ;
        endcase
    end

    // Indices wrap naturally because N is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cidx    <= '0;
            sidx    <= '0;
            pending <= 1'b0;
        end else begin
            if (coef_wr) cidx <= cidx + 1'b1;
            if (in_acc)  sidx <= sidx + 1'b1;
            if (state == S_RUN && reload) begin
                pending <= 1'b1;
            end else if (state == S_LOAD) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (coef_wr) begin
            coef_re_mem[cidx] <= coef_real;
            coef_im_mem[cidx] <= coef_img;
        end
    end

    // Stage 1: the four partial products.
    logic signed [DW-1:0] ar, ai, br, bi;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
    logic                 s1_valid, s1_last, s1_conj;

    assign ar = in_real;
    assign ai = in_img;
    assign br = coef_re_mem[sidx];
    assign bi = coef_im_mem[sidx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_conj  <= 1'b0;
            p_rr     <= '0;
            p_ii     <= '0;
            p_ir     <= '0;
            p_ri     <= '0;
        end else begin
            s1_valid <= in_acc;
            if (in_acc) begin
                p_rr    <= PW'(ar) * PW'(br);
                p_ii    <= PW'(ai) * PW'(bi);
                p_ir    <= PW'(ai) * PW'(br);
                p_ri    <= PW'(ar) * PW'(bi);
                s1_last <= (sidx == AW'(N - 1));
                s1_conj <= conj_en;
            end
        end
    end

    // Stage 2 combinational part: full-precision sums, conjugation, floor shift.
    logic signed [SW-1:0] re_sum, im_sum, im_fin, re_sh, im_sh;

    always_comb begin
        re_sum = SW'(p_rr) - SW'(p_ii);
        im_sum = SW'(p_ir) + SW'(p_ri);
        im_fin = s1_conj ? -im_sum : im_sum;
        re_sh  = re_sum >>> FRAC;
        im_sh  = im_fin >>> FRAC;
    end

    logic [DW-1:0] re_red, im_red;

`ifdef MC_FMULT_SAT_EN
    localparam logic signed [SW-1:0] MAX_W = {{(DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_W = ~MAX_W;

    logic clamp;

    always_comb begin
        re_red = re_sh[DW-1:0];
        im_red = im_sh[DW-1:0];
        clamp  = 1'b0;
        if (re_sh > MAX_W) begin
            re_red = MAX_W[DW-1:0];
            clamp  = 1'b1;
        end else if (re_sh < MIN_W) begin
            re_red = MIN_W[DW-1:0];
            clamp  = 1'b1;
        end
        if (im_sh > MAX_W) begin
            im_red = MAX_W[DW-1:0];
            clamp  = 1'b1;
        end else if (im_sh < MIN_W) begin
            im_red = MIN_W[DW-1:0];
            clamp  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (s1_valid && clamp) begin
            sat_flag <= 1'b1;
        end
    end
`else
    // Two's-complement wrap: only the low DW bits of the shifted value survive.
    logic unused_hi;

    assign re_red    = re_sh[DW-1:0];
    assign im_red    = im_sh[DW-1:0];
    assign unused_hi = ^{re_sh[SW-1:DW], im_sh[SW-1:DW]};
    assign sat_flag  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_real   <= '0;
            out_img    <= '0;
        end else begin
            out_valid  <= s1_valid;
            frame_done <= s1_valid && s1_last;
            if (s1_valid) begin
                out_real <= re_red;
                out_img  <= im_red;
            end
        end
    end

endmodule
